// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instr} entries with a single-cycle flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem_q[rd_ptr];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: the storage array is reset too, so head outputs are defined (not X) before the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, combinational-read imem interface, fetch queue to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        misalign_err
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  logic            misalign_q;
  logic            push;
  logic            pop;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count;
  fetch_entry_t    q_head;
  fetch_entry_t    q_din;

  // out_valid comes only from registered occupancy, never from out_ready.
  assign out_valid = (q_count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = !redirect_valid && (!q_full || pop);

  assign q_din.pc    = pc_q;
  assign q_din.instr = imem_rdata;

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop && !redirect_valid),
    .flush (redirect_valid),
    .din   (q_din),
    .head  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        pc_q <= align_pc(redirect_pc);
      end else if (push) begin
        pc_q <= pc_q + INSTR_BYTES;
      end
    end
  end

  assign imem_addr    = pc_q;
  assign misalign_err = misalign_q;
  assign out_instr    = q_head.instr;
  assign out_pc       = q_head.pc;
  assign out_pc_plus4 = q_head.pc + INSTR_BYTES;

  // Occupancy flags must agree with the count.
  assert property (@(posedge clk) disable iff (rst) q_empty == (q_count == '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized redirect/backpressure.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] plus4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] next_fill_pc;
  logic        mis_pend;
  logic        mis_exp;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .QDEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .misalign_err   (misalign_err)
  );

  // Instruction memory: word k holds 0x1000_0000 + k.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference stream: after reset or redirect, decode sees consecutive words from the base.
  function automatic void top_up();
    exp_t e;
    while (exp_q.size() < 16) begin
      e.pc    = next_fill_pc;
      e.instr = mem_word(next_fill_pc);
      e.plus4 = next_fill_pc + 32'd4;
      exp_q.push_back(e);
      next_fill_pc = next_fill_pc + 32'd4;
    end
  endfunction

  function automatic void restart_stream(input logic [31:0] base);
    exp_q.delete();
    next_fill_pc = {base[31:2], 2'b00};
    top_up();
  endfunction

  task automatic next_cycle();
    top_up();
    @(posedge clk);
    #1;
    mis_exp  = mis_pend;
    mis_pend = 1'b0;
    check("misalign_err", {31'b0, misalign_err}, {31'b0, mis_exp});
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    mis_pend       = (target[1:0] != 2'b00);
    restart_stream(target);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    mis_pend       = 1'b0;
    restart_stream(RST_PC);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_misalign", {31'b0, misalign_err}, 32'd0);
    check("rst_imem_addr", imem_addr, RST_PC);
    check("rst_head_not_x", {31'b0, $isunknown({out_instr, out_pc, out_pc_plus4})}, 32'd0);
    rst     = 1'b0;
    mis_exp = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever decode takes the head at the coming edge.
  logic        pv = 1'b0;
  logic        prev_pop = 1'b0;
  logic        prev_redir = 1'b0;
  logic [31:0] ppc = '0;

  always @(negedge clk) begin
    exp_t e;
    logic pop_now;
    if (rst !== 1'b0) begin
      pv = 1'b0;
    end else begin
      if (pv && !prev_pop && !prev_redir) begin
        check("head_hold_valid", {31'b0, out_valid}, 32'd1);
        check("head_hold_pc", out_pc, ppc);
      end
      pop_now = out_valid && out_ready && !redirect_valid;
      if (pop_now) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", out_pc, e.pc);
          check("deliver_instr", out_instr, e.instr);
          check("deliver_pc_plus4", out_pc_plus4, e.plus4);
          pops++;
        end
      end
      pv         = out_valid;
      ppc        = out_pc;
      prev_pop   = pop_now;
      prev_redir = redirect_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops_before;
    logic [31:0] t;
    logic was_redir;

    rst            = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mis_pend       = 1'b0;
    mis_exp        = 1'b0;

    // Reset and back-to-back streaming.
    do_reset();
    check("first_addr", imem_addr, RST_PC);
    next_cycle();
    check("lat_valid", {31'b0, out_valid}, 32'd1);
    check("lat_pc", out_pc, 32'h100);
    check("lat_instr", out_instr, 32'h1000_0040);
    for (int k = 1; k <= 4; k++) begin
      check("stream_addr", imem_addr, RST_PC + 32'(4 * k));
      next_cycle();
    end

    // Backpressure from a fresh reset: queue fills, PC holds, then drains in order.
    out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 6; k++) next_cycle();
    check("stall_addr", imem_addr, 32'h108);
    check("stall_valid", {31'b0, out_valid}, 32'd1);
    check("stall_head", out_pc, 32'h100);
    out_ready = 1'b1;
    next_cycle();
    check("release_addr", imem_addr, 32'h10C);
    for (int k = 0; k < 4; k++) next_cycle();

    // Full queue, redirect with out_ready high: nothing consumed, queue flushed.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) next_cycle();
    out_ready = 1'b1;
    redirect(32'h0000_0200);
    next_cycle();
    redirect_valid = 1'b0;
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("redir_addr", imem_addr, 32'h200);
    next_cycle();
    check("redir_head_valid", {31'b0, out_valid}, 32'd1);
    check("redir_head_pc", out_pc, 32'h200);
    check("redir_head_plus4", out_pc_plus4, 32'h204);
    for (int k = 0; k < 3; k++) next_cycle();

    // Misaligned redirect: PC aligned down, one-cycle error pulse.
    redirect(32'h0000_0203);
    next_cycle();
    redirect_valid = 1'b0;
    check("mis_pulse_high", {31'b0, misalign_err}, 32'd1);
    check("mis_addr", imem_addr, 32'h200);
    next_cycle();
    check("mis_pulse_low", {31'b0, misalign_err}, 32'd0);
    check("mis_next_addr", imem_addr, 32'h204);
    check("mis_head_pc", out_pc, 32'h200);

    // PC wrap at the top of the address space.
    redirect(32'hFFFF_FFF8);
    next_cycle();
    redirect_valid = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    next_cycle();
    check("wrap_head0", out_pc, 32'hFFFF_FFF8);
    check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    next_cycle();
    check("wrap_head1", out_pc, 32'hFFFF_FFFC);
    check("wrap_plus4", out_pc_plus4, 32'h0000_0000);
    check("wrap_addr2", imem_addr, 32'h0000_0000);
    next_cycle();
    check("wrap_head2", out_pc, 32'h0000_0000);

    // Asynchronous reset mid-stream: out_valid drops before any clock edge.
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst      = 1'b1;
    mis_pend = 1'b0;
    restart_stream(RST_PC);
    #2;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_addr", imem_addr, RST_PC);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    check("resume_pc", out_pc, RST_PC);

    // Randomized backpressure and redirects against the stream model.
    pops_before = pops;
    was_redir   = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        t = $urandom;
        if ($urandom_range(0, 1) == 1) t[1:0] = 2'b00;
        redirect(t);
      end else begin
        redirect_valid = 1'b0;
      end
      was_redir = redirect_valid;
      next_cycle();
      if (was_redir) check("rand_flush_valid", {31'b0, out_valid}, 32'd0);
    end
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    for (int k = 0; k < 4; k++) next_cycle();
    check("rand_progress", {31'b0, (pops - pops_before) > 500}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RV32I core. It sits directly upstream of the instruction memory: it holds the program counter, drives the word address into the combinational-read memory, and captures the returned instruction word. Fetched instructions are buffered in a small queue and passed to decode through a valid/ready handshake. Branch/jump redirects from execute flush the queue.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `QDEPTH`, default 2: fetch queue depth in entries; must be a power of two, ≥ 2.

Ports:
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `imem_addr` output 32: byte address to instruction memory `A`; always equals the current PC.
- `imem_rdata` input 32: instruction word from memory `RD`; combinational, valid in the same cycle as `imem_addr`.
- `redirect_valid` input 1: execute-stage request to change the PC this cycle.
- `redirect_pc` input 32: redirect target byte address.
- `out_valid` output 1: queue head holds a valid instruction.
- `out_ready` input 1: decode accepts the head this cycle.
- `out_instr` output 32: instruction at the queue head.
- `out_pc` output 32: PC of the head instruction.
- `out_pc_plus4` output 32: `out_pc + 4`, modulo 2^32.
- `misalign_err` output 1: one-cycle registered pulse after a redirect with `redirect_pc[1:0] != 0`.

## Operation
- State: PC register, circular queue of `{pc, instr}` entries, and an occupancy count of width `$clog2(QDEPTH)+1`.
- `push` = `!redirect_valid && (count < QDEPTH || pop)`.
- `pop` = `out_valid && out_ready`.
- On `push`: enqueue `{pc, imem_rdata}`; `pc <= pc + 4`, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
- When the queue is full with no pop: PC holds and memory is re-read with the same address. The stall is lossless.
- Redirect has priority over everything else:
  - count resets to 0 and the read/write pointers reset;
  - any pop that cycle is ignored;
  - `pc <= {redirect_pc[31:2], 2'b00}`;
  - no push.
- Misaligned redirect (`redirect_pc[1:0] != 0`): the PC is force-aligned as above and `misalign_err` is 1 in the following cycle only.
- Simultaneous push and pop when full: both happen and count is unchanged.
- Simultaneous push and pop when empty: not possible, since `out_valid = 0`.
- `out_valid = (count != 0)`. `out_instr`, `out_pc` and `out_pc_plus4` come from the head entry. Their value is don't-care when `out_valid = 0`, but the bench expects them stable (not X) after reset.
- Once `out_valid` is asserted, the head stays stable until popped or flushed.
- Reset values: PC = `RESET_PC`, count = 0, pointers = 0, `out_valid` = 0, `misalign_err` = 0, `imem_addr` = `RESET_PC`.
- Reset asserted mid-operation: the queue empties immediately (asynchronously). Fetch restarts at `RESET_PC` on the first edge after deassertion.

## Timing
- Fetch latency: an instruction addressed in cycle N appears at the head in cycle N+1 if the queue was empty.
- Sustained throughput: 1 instruction/cycle while `out_ready = 1`.
- Redirect sampled at edge E:
  - `out_valid = 0` in cycle E+1;
  - `imem_addr = target` in cycle E+1;
  - target instruction at the head in cycle E+2.
- `misalign_err` rises after edge E and falls after edge E+1.
- `out_ready` may depend combinationally on `out_valid`. `out_valid` must not depend combinationally on `out_ready`.
- `imem_addr` is driven only from the PC register; there is no combinational path from `redirect_*` to `imem_addr`.

## Structure
- Package `fetch_pkg`:
  - `XLEN = 32`
  - `DEFAULT_RESET_PC`
  - `typedef struct packed { logic [31:0] pc; logic [31:0] instr; } fetch_entry_t`
- Sub-module `fetch_queue`: parameterised circular FIFO of `fetch_entry_t`. It has `push`, `pop` and `flush` inputs, `count`, `full` and `empty` outputs, and a head-data output.
- `fetch_unit` contains the PC register, the push/pop/redirect control, and the misalignment flag.

## Test plan
- Reset with `RESET_PC` = 32'h0000_0100 and memory word k = 32'h1000_0000+k, `out_ready` = 1: `imem_addr` = 0x100, 0x104, … and decode receives `(pc, instr)` = (0x100, 0x1000_0040), then (0x104, 0x1000_0041), … back-to-back.
- Hold `out_ready` = 0 for 5 cycles: count saturates at 2 and `imem_addr` holds at 0x108. After release, 0x100, 0x104, 0x108 are delivered in order with no loss or duplication.
- Redirect to 0x0000_0200 while the queue holds 2 entries: `out_valid` = 0 the next cycle, then `out_pc` = 0x200, `out_pc_plus4` = 0x204.
- Redirect to 0x0000_0203: PC becomes 0x200, `misalign_err` is high for exactly one cycle, and fetch continues at 0x204.
- Redirect asserted together with `out_ready` = 1 and queue full: the head is not consumed and the queue is empty the next cycle.
- Start at PC 32'hFFFF_FFF8: the sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, and `out_pc_plus4` for 0xFFFF_FFFC is 0x0000_0000.
- Assert `rst` mid-stream: `out_valid` drops without waiting for a clock edge, and fetch resumes at `RESET_PC`.
